// File: rtl/hnf_rxchan.sv
// hnf_rxchan: receive side of a credited flit link.
//
// Grants L-credits to the sender (rxlcrdv), accepts inbound flits against
// those credits into a circular FIFO, and presents the oldest entry to a
// ready/valid consumer. A flit arriving while the sender holds no credit is
// dropped and latches proto_err until reset.
//
// Ports:
//   clock       rising-edge clock
//   reset       asynchronous active-low reset
//   rxflit      inbound flit
//   rxflitv     inbound flit valid
//   rxflitpend  early-warning flit pending (registered into flitpend_q)
//   rxlcrdv     registered credit grant, one credit per asserted cycle
//   link_en     1 = grant credits, 0 = stop granting
//   deq_flit    head entry (don't-care while deq_valid=0)
//   deq_valid   head entry present
//   deq_ready   consumer accepts the head entry
//   occupancy   entries held
//   crd_out     credits currently held by the sender
//   crd_idle    no credits outstanding and queue empty
//   proto_err   sticky: flit received with no credit outstanding
module hnf_rxchan #(
  parameter int unsigned FLIT_W  = 128,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned NUM_CRD = DEPTH,
  localparam int unsigned OCC_W  = $clog2(DEPTH + 1),
  localparam int unsigned CRD_W  = $clog2(NUM_CRD + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [FLIT_W-1:0] rxflit,
  input  logic              rxflitv,
  input  logic              rxflitpend,
  output logic              rxlcrdv,
  input  logic              link_en,
  output logic [FLIT_W-1:0] deq_flit,
  output logic              deq_valid,
  input  logic              deq_ready,
  output logic [OCC_W-1:0]  occupancy,
  output logic [CRD_W-1:0]  crd_out,
  output logic              crd_idle,
  output logic              proto_err
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SUM_W = OCC_W + 1;

  localparam logic [CRD_W-1:0] CRD_MAX  = CRD_W'(NUM_CRD);
  localparam logic [CRD_W-1:0] CRD_ONE  = CRD_W'(1);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [SUM_W-1:0] SUM_MAX  = SUM_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  // One settling cycle after reset before the first grant goes out.
  typedef enum logic {
    ST_WAKE,
    ST_LIVE
  } link_state_e;

  link_state_e       state_q, state_d;
  logic              flitpend_q, flitpend_d;
  logic              rxlcrdv_q, rxlcrdv_d;
  logic [CRD_W-1:0]  crd_q, crd_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              err_q, err_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FLIT_W-1:0] mem_q [DEPTH];

  logic              crd_nz;
  logic              accept_pend;
  logic              accept_late;
  logic              accept;
  logic              pop;
  logic [SUM_W-1:0]  sum_d;

  always_comb begin
    flitpend_d  = rxflitpend;
    crd_nz      = (crd_q != '0);
    // A flit without a preceding pending indication is still legal as long
    // as a credit backs it; both cases are accepted identically.
    accept_pend = rxflitv & flitpend_q & crd_nz;
    accept_late = rxflitv & ~flitpend_q & crd_nz;
    accept      = accept_pend | accept_late;
    pop         = (occ_q != '0) & deq_ready;
    err_d       = err_q | (rxflitv & ~crd_nz);

    crd_d = crd_q;
    if (rxlcrdv_q && !accept) begin
      crd_d = crd_q + CRD_ONE;
    end else if (!rxlcrdv_q && accept) begin
      crd_d = crd_q - CRD_ONE;
    end

    occ_d = occ_q;
    if (accept && !pop) begin
      occ_d = occ_q + OCC_ONE;
    end else if (!accept && pop) begin
      occ_d = occ_q - OCC_ONE;
    end

    wr_ptr_d = wr_ptr_q;
    if (accept) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
    end
    rd_ptr_d = rd_ptr_q;
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
    end

    state_d = ST_LIVE;

    // The grant is registered, so the credit it carries lands in crd_q one
    // edge later. Judging against the post-edge counts (which already include
    // any grant currently on the wire) keeps crd_out within NUM_CRD and
    // crd_out+occupancy within DEPTH without over-issuing.
    sum_d     = SUM_W'(crd_d) + SUM_W'(occ_d);
    rxlcrdv_d = (state_q == ST_LIVE) & link_en & (crd_d < CRD_MAX) & (sum_d < SUM_MAX);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_WAKE;
      flitpend_q <= 1'b0;
      rxlcrdv_q  <= 1'b0;
      crd_q      <= '0;
      occ_q      <= '0;
      err_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      flitpend_q <= flitpend_d;
      rxlcrdv_q  <= rxlcrdv_d;
      crd_q      <= crd_d;
      occ_q      <= occ_d;
      err_q      <= err_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage carries no reset; contents are only observed while deq_valid=1.
  always_ff @(posedge clock) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= rxflit;
    end
  end

  assign rxlcrdv   = rxlcrdv_q;
  assign deq_valid = (occ_q != '0);
  assign deq_flit  = mem_q[rd_ptr_q];
  assign occupancy = occ_q;
  assign crd_out   = crd_q;
  assign crd_idle  = (crd_q == '0) && (occ_q == '0);
  assign proto_err = err_q;

endmodule

// File: tb/tb_hnf_rxchan.sv
// tb_hnf_rxchan: randomized and directed stimulus for hnf_rxchan with a
// behavioural credit/occupancy model and a flit scoreboard drained by an
// independent monitor.
module tb_hnf_rxchan;

  localparam int unsigned FW      = 32;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned NUM_CRD = 4;
  localparam int unsigned OCC_W   = $clog2(DEPTH + 1);
  localparam int unsigned CRD_W   = $clog2(NUM_CRD + 1);

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [FW-1:0]    rxflit = '0;
  logic             rxflitv = 1'b0;
  logic             rxflitpend = 1'b0;
  logic             rxlcrdv;
  logic             link_en = 1'b0;
  logic [FW-1:0]    deq_flit;
  logic             deq_valid;
  logic             deq_ready = 1'b0;
  logic [OCC_W-1:0] occupancy;
  logic [CRD_W-1:0] crd_out;
  logic             crd_idle;
  logic             proto_err;

  hnf_rxchan #(
    .FLIT_W (FW),
    .DEPTH  (DEPTH),
    .NUM_CRD(NUM_CRD)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rxflit    (rxflit),
    .rxflitv   (rxflitv),
    .rxflitpend(rxflitpend),
    .rxlcrdv   (rxlcrdv),
    .link_en   (link_en),
    .deq_flit  (deq_flit),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .occupancy (occupancy),
    .crd_out   (crd_out),
    .crd_idle  (crd_idle),
    .proto_err (proto_err)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Scoreboard of flits the channel owes the consumer, oldest first.
  logic [FW-1:0] exp_q [$];

  // Reference view of the link: credits the sender holds, entries queued,
  // whether a grant is on the wire this cycle, the sticky error, and whether
  // at least one edge has passed since reset.
  int m_crd;
  int m_occ;
  bit m_gnt;
  bit m_err;
  bit m_live;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // What one clock edge does to the link, given the inputs present at it.
  task automatic model_edge();
    bit acc;
    bit pop;
    acc = rxflitv && (m_crd > 0);
    pop = deq_ready && (m_occ > 0);
    if (rxflitv && m_crd == 0) m_err = 1'b1;
    if (acc) exp_q.push_back(rxflit);
    m_crd = m_crd + int'(m_gnt) - int'(acc);
    m_occ = m_occ + int'(acc) - int'(pop);
    // Another credit may be handed out only if, once the sender owns it,
    // its own credit limit holds and every credit still has a free slot.
    m_gnt = m_live && link_en && (m_crd + 1 <= NUM_CRD) && (m_crd + m_occ + 1 <= DEPTH);
    m_live = 1'b1;
  endtask

  task automatic check_state();
    chk("rxlcrdv",   rxlcrdv,   m_gnt);
    chk("crd_out",   crd_out,   m_crd);
    chk("occupancy", occupancy, m_occ);
    chk("deq_valid", deq_valid, m_occ > 0);
    chk("crd_idle",  crd_idle,  (m_crd == 0) && (m_occ == 0));
    chk("proto_err", proto_err, m_err);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    model_edge();
    check_state();
  endtask

  task automatic idle_inputs();
    rxflitv    = 1'b0;
    rxflit     = '0;
    rxflitpend = 1'b0;
    deq_ready  = 1'b0;
  endtask

  task automatic send_flit();
    rxflitv    = 1'b1;
    rxflit     = FW'($urandom);
    rxflitpend = 1'($urandom_range(0, 1));
  endtask

  // Asserts reset between edges and checks the outputs before any clock edge.
  task automatic do_reset();
    idle_inputs();
    #2 reset = 1'b0;
    #1;
    chk("rst_rxlcrdv",   rxlcrdv,   1'b0);
    chk("rst_deq_valid", deq_valid, 1'b0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_crd_out",   crd_out,   0);
    chk("rst_proto_err", proto_err, 1'b0);
    chk("rst_crd_idle",  crd_idle,  1'b1);
    exp_q.delete();
    m_crd  = 0;
    m_occ  = 0;
    m_gnt  = 1'b0;
    m_err  = 1'b0;
    m_live = 1'b0;
    @(negedge clock);
    #2 reset = 1'b1;
  endtask

  // Consumer-side monitor: every handshake must deliver the oldest owed flit.
  always @(negedge clock) begin
    if (reset && deq_valid && deq_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL deq_flit: got %0h expected no entry at %0t", deq_flit, $time);
      end else begin
        chk("deq_flit", deq_flit, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int grants;
    int sent;
    int pre_crd;
    int pre_occ;
    int budget;

    do_reset();

    // Credit ramp with no traffic.
    link_en = 1'b1;
    grants  = 0;
    step();
    chk("first_grant_delay", rxlcrdv, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      if (rxlcrdv) grants++;
    end
    chk("ramp_grants", grants, NUM_CRD);
    chk("ramp_crd", crd_out, NUM_CRD);
    chk("ramp_hold", rxlcrdv, 1'b0);

    // Fill the queue with the consumer stalled.
    sent = 0;
    for (int i = 0; i < 60 && sent < DEPTH; i++) begin
      if (m_crd > 0) begin
        send_flit();
        sent++;
      end else begin
        rxflitv = 1'b0;
      end
      step();
    end
    rxflitv = 1'b0;
    chk("fill_sent", sent, DEPTH);
    step();
    chk("fill_occ", occupancy, DEPTH);
    chk("fill_crd", crd_out, 0);
    chk("fill_no_grant", rxlcrdv, 1'b0);

    // Drain; pointers wrap on the next fill.
    deq_ready = 1'b1;
    for (int i = 0; i < 40 && m_occ > 0; i++) step();
    chk("drain_empty", occupancy, 0);
    for (int i = 0; i < 20 && !(m_crd == NUM_CRD && !m_gnt); i++) step();
    chk("regrant_crd", crd_out, NUM_CRD);

    // Grant, accept and pop in the same cycle.
    deq_ready = 1'b0;
    send_flit();
    step();
    rxflitv = 1'b0;
    chk("simul_pre_grant", rxlcrdv, 1'b1);
    pre_crd = m_crd;
    pre_occ = m_occ;
    send_flit();
    deq_ready = 1'b1;
    step();
    rxflitv = 1'b0;
    chk("simul_crd", crd_out, pre_crd);
    chk("simul_occ", occupancy, pre_occ);
    for (int i = 0; i < 20 && (m_occ > 0 || m_crd != NUM_CRD || m_gnt); i++) step();

    // Deactivation with three credits left at the sender.
    link_en = 1'b0;
    send_flit();
    step();
    rxflitv = 1'b0;
    chk("deact_crd", crd_out, 3);
    grants = 0;
    budget = 0;
    while (m_crd > 0 && budget < 30) begin
      if ($urandom_range(0, 2) != 0) send_flit();
      else rxflitv = 1'b0;
      deq_ready = 1'($urandom_range(0, 1));
      step();
      if (rxlcrdv) grants++;
      budget++;
    end
    rxflitv   = 1'b0;
    deq_ready = 1'b1;
    for (int i = 0; i < 20 && m_occ > 0; i++) begin
      step();
      if (rxlcrdv) grants++;
    end
    chk("deact_no_grant", grants, 0);
    chk("deact_idle", crd_idle, 1'b1);

    // Flit with no credit outstanding.
    pre_occ = m_occ;
    send_flit();
    step();
    rxflitv = 1'b0;
    chk("perr_set", proto_err, 1'b1);
    chk("perr_occ", occupancy, pre_occ);
    step();
    chk("perr_not_delivered", deq_valid, 1'b0);

    // Random traffic; the error must stay latched throughout.
    for (int i = 0; i < 400; i++) begin
      link_en = ($urandom_range(0, 9) != 0);
      if ((m_crd > 0 && $urandom_range(0, 1) == 1) || $urandom_range(0, 39) == 0) send_flit();
      else rxflitv = 1'b0;
      deq_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    rxflitv = 1'b0;
    chk("perr_sticky", proto_err, 1'b1);

    // Reset with five entries queued.
    link_en   = 1'b1;
    deq_ready = 1'b0;
    for (int i = 0; i < 60 && m_occ < 5; i++) begin
      if (m_crd > 0 && m_occ + 1 < 5 + 1) send_flit();
      else rxflitv = 1'b0;
      step();
    end
    rxflitv = 1'b0;
    chk("midrst_occ", occupancy, 5);
    do_reset();

    // Link comes back clean.
    link_en = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("post_rst_crd", crd_out, NUM_CRD);
    for (int i = 0; i < 150; i++) begin
      if (m_crd > 0 && $urandom_range(0, 1) == 1) send_flit();
      else rxflitv = 1'b0;
      deq_ready = 1'($urandom_range(0, 1));
      step();
    end
    rxflitv   = 1'b0;
    deq_ready = 1'b1;
    for (int i = 0; i < 30 && m_occ > 0; i++) step();
    chk("final_scoreboard_empty", exp_q.size(), 0);
    chk("final_no_err", proto_err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
